// File: rtl/mac_ctrl.sv
// Sequencer for an external pipelined MAC element: streams len operand pairs,
// drains the load/mult/acc pipeline, then holds the accumulated dot product.
module mac_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len_in,
    output logic                 busy,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [WIDTH-1:0]     mac_a,
    output logic [WIDTH-1:0]     mac_b,
    output logic                 mac_load_en,
    output logic                 mac_mult_en,
    output logic                 mac_acc_en,
    output logic                 mac_clr_n,
    input  logic [4*WIDTH-1:0]   mac_acc,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*WIDTH-1:0]   res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_e;

    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [1:0]       DRAIN_END = 2'd2;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           drain_q, drain_d;
    logic [4*WIDTH-1:0]   res_q, res_d;
    logic                 mult_en_q;
    logic                 acc_en_q;
    logic                 beat_xfer;

    assign op_ready    = (state_q == S_STREAM);
    assign beat_xfer   = op_valid & op_ready;
    assign mac_a       = op_a;
    assign mac_b       = op_b;
    assign mac_load_en = beat_xfer;
    assign mac_mult_en = mult_en_q;
    assign mac_acc_en  = acc_en_q;
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_RESULT);
    assign res_data    = res_q;
    // Clear is also forced while reset is held so the MAC starts from zero.
    assign mac_clr_n   = reset & (state_q != S_CLEAR);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_in;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                drain_d = '0;
                state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                if (beat_xfer) begin
                    cnt_d = cnt_q + LEN_ONE;
                    if (cnt_d == len_q) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Three cycles: last beat multiplies, accumulates, then is sampled.
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_END) begin
                    res_d   = mac_acc;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            res_q   <= res_d;
        end
    end

    // Enable chain follows each beat, so gaps in op_valid become bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_en_q <= 1'b0;
            acc_en_q  <= 1'b0;
        end else begin
            mult_en_q <= beat_xfer;
            acc_en_q  <= mult_en_q;
        end
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench for mac_ctrl with a behavioural load/mult/acc MAC element
// attached; expected results are hand-computed constants.
module tb_mac_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  len_in;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_load_en;
    logic        mac_mult_en;
    logic        mac_acc_en;
    logic        mac_clr_n;
    logic [31:0] mac_acc;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_pulses = 0;
    int ready_hi   = 0;

    always #5 clk = ~clk;

    mac_ctrl #(.WIDTH(8), .LEN_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .len_in(len_in), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_load_en(mac_load_en),
        .mac_mult_en(mac_mult_en), .mac_acc_en(mac_acc_en), .mac_clr_n(mac_clr_n),
        .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    // External MAC element: load, multiply, accumulate, each on its own enable.
    logic [7:0]  a_r = '0;
    logic [7:0]  b_r = '0;
    logic [15:0] prod_r = '0;
    logic [31:0] acc_r = '0;
    assign mac_acc = acc_r;

    always @(posedge clk) begin
        if (mac_load_en) begin
            a_r <= mac_a;
            b_r <= mac_b;
        end
        if (mac_mult_en) prod_r <= 16'(a_r) * 16'(b_r);
        if (!mac_clr_n) acc_r <= '0;
        else if (mac_acc_en) acc_r <= acc_r + 32'(prod_r);
    end

    always @(negedge clk) begin
        if (mac_acc_en) acc_pulses++;
        if (op_ready) ready_hi++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [4:0] len);
        start  = 1'b1;
        len_in = len;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        while (!op_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check_eq("beat_timeout", 0, 1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_result(output int k);
        k = 0;
        while (!res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check_eq("result_timeout", 0, 1);
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int p0;
        reset = 1'b0; start = 1'b0; len_in = '0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_op_ready", op_ready, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_clr_n", mac_clr_n, 0);
        check_eq("rst_mult_en", mac_mult_en, 0);
        check_eq("rst_acc_en", mac_acc_en, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);

        // Basic dot product: 1*2 + 3*4 + 5*6 = 44
        start_job(5'd3);
        check_eq("t1_clear_pulse", mac_clr_n, 0);
        send_beat(8'd1, 8'd2);
        send_beat(8'd3, 8'd4);
        send_beat(8'd5, 8'd6);
        wait_result(k);
        check_eq("t1_latency", k, 3);
        check_eq("t1_res", res_data, 44);
        take_result("t1_idle");

        // Stalled stream: 2 * 255*255 = 130050, two accumulate pulses
        p0 = acc_pulses;
        start_job(5'd2);
        send_beat(8'd255, 8'd255);
        repeat (3) @(negedge clk);
        send_beat(8'd255, 8'd255);
        wait_result(k);
        check_eq("t2_res", res_data, 130050);
        check_eq("t2_acc_pulses", acc_pulses - p0, 2);
        take_result("t2_idle");

        // Zero length, then back-pressure on the result
        p0 = ready_hi;
        start_job(5'd0);
        wait_result(k);
        check_eq("t3_res", res_data, 0);
        check_eq("t3_op_ready_cnt", ready_hi - p0, 0);
        repeat (5) @(negedge clk);
        check_eq("t3_hold_valid", res_valid, 1);
        check_eq("t3_hold_data", res_data, 0);
        check_eq("t3_hold_busy", busy, 1);
        take_result("t3_idle");

        // Back-to-back jobs: 7*8 = 56, then 2*3 = 6
        start_job(5'd1);
        send_beat(8'd7, 8'd8);
        wait_result(k);
        check_eq("t4_res1", res_data, 56);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start_job(5'd1);
        send_beat(8'd2, 8'd3);
        wait_result(k);
        check_eq("t4_res2", res_data, 6);
        take_result("t4_idle");

        // Reset mid-stream, then a fresh 9*9 = 81 job
        start_job(5'd3);
        send_beat(8'd4, 8'd5);
        op_valid = 1'b1;
        reset = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_op_ready", op_ready, 0);
        check_eq("t5_load_en", mac_load_en, 0);
        check_eq("t5_mult_en", mac_mult_en, 0);
        check_eq("t5_acc_en", mac_acc_en, 0);
        check_eq("t5_res_valid", res_valid, 0);
        check_eq("t5_res_data", res_data, 0);
        check_eq("t5_clr_n", mac_clr_n, 0);
        repeat (2) @(negedge clk);
        op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_post_busy", busy, 0);
        start_job(5'd1);
        send_beat(8'd9, 8'd9);
        wait_result(k);
        check_eq("t5_res", res_data, 81);
        take_result("t5_idle");

        // Ignored start in STREAM and RESULT: 10*20 + 3*3 = 209
        start_job(5'd2);
        send_beat(8'd10, 8'd20);
        start_job(5'd1);
        check_eq("t6_stream_busy", busy, 1);
        check_eq("t6_stream_ready", op_ready, 1);
        send_beat(8'd3, 8'd3);
        wait_result(k);
        check_eq("t6_res", res_data, 209);
        start_job(5'd1);
        check_eq("t6_result_hold", res_valid, 1);
        check_eq("t6_result_data", res_data, 209);
        take_result("t6_idle");
        repeat (8) @(negedge clk);
        check_eq("t6_no_extra_valid", res_valid, 0);
        check_eq("t6_no_extra_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
